// File: rtl/pwm_bitplane_mem_if.sv
// rtl/pwm_bitplane_mem_if.sv - host write port, commit/latch control and engine read port
// master = host + pwm engine side, slave = pwm_bitplane_mem
interface pwm_bitplane_mem_if #(
  parameter int PWM_WIDTH = 16,
  parameter int NUM_PWM   = 4
);
  localparam int CHAN_W = (NUM_PWM > 1) ? $clog2(NUM_PWM) : 1;
  localparam int ADDR_W = (PWM_WIDTH > 1) ? $clog2(PWM_WIDTH) : 1;

  logic                 wr_valid;
  logic                 wr_ready;
  logic [CHAN_W-1:0]    wr_chan;
  logic [PWM_WIDTH-1:0] wr_duty;
  logic                 commit;
  logic                 frame_pending;
  logic [ADDR_W-1:0]    pwm_addr;
  logic [NUM_PWM-1:0]   pwm_data;
  logic                 latch_mem;

  modport master (
    output wr_valid, wr_chan, wr_duty, commit, pwm_addr, latch_mem,
    input  wr_ready, frame_pending, pwm_data
  );

  modport slave (
    input  wr_valid, wr_chan, wr_duty, commit, pwm_addr, latch_mem,
    output wr_ready, frame_pending, pwm_data
  );
endinterface

// File: rtl/pwm_bitplane_mem.sv
// rtl/pwm_bitplane_mem.sv - double-buffered duty-to-bitplane store for the pwm engine
// Optional copy-forward of the new active frame into the shadow: PWM_COPY_FORWARD_EN
module pwm_bitplane_mem #(
  parameter int PWM_WIDTH = 16,
  parameter int NUM_PWM   = 4
) (
  input  logic               clk,
  input  logic               rst,
  pwm_bitplane_mem_if.slave  bus
);
  localparam int ADDR_W = (PWM_WIDTH > 1) ? $clog2(PWM_WIDTH) : 1;

  typedef enum logic {S_IDLE, S_COPY} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_sel;
  logic                r_pending;
  logic [ADDR_W-1:0]   r_cnt;
  logic [NUM_PWM-1:0]  r_buf [2][PWM_WIDTH];

  logic                w_ready;
  logic                w_fire;
  logic                w_chan_ok;
  logic                w_commit_ok;
  logic                w_swap;
  logic                w_shadow;
  logic [NUM_PWM-1:0]  w_rd;

  assign w_ready     = (r_state == S_IDLE) && !r_pending;
  assign w_fire      = bus.wr_valid && w_ready;
  assign w_chan_ok   = int'(bus.wr_chan) < NUM_PWM;
  assign w_commit_ok = bus.commit && w_ready;
  assign w_swap      = bus.latch_mem && (r_pending || w_commit_ok);
  assign w_shadow    = ~r_sel;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
`ifdef PWM_COPY_FORWARD_EN
        if (w_swap) w_state_nxt = S_COPY;
`endif
      end
      S_COPY: if (r_cnt == ADDR_W'(PWM_WIDTH - 1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sel     <= 1'b0;
      r_pending <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_swap) begin
        r_sel     <= ~r_sel;
        r_pending <= 1'b0;
      end else if (w_commit_ok) begin
        r_pending <= 1'b1;
      end
      if (r_state == S_COPY) r_cnt <= r_cnt + 1'b1;
      else                   r_cnt <= '0;
    end
  end

  // A write landing on the swap edge goes to the old shadow, i.e. the frame being committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < PWM_WIDTH; k++)
          r_buf[i][k] <= '0;
    end else begin
      if (w_fire && w_chan_ok)
        for (int k = 0; k < PWM_WIDTH; k++)
          r_buf[w_shadow][k][bus.wr_chan] <= bus.wr_duty[k];
      if (r_state == S_COPY)
        r_buf[w_shadow][r_cnt] <= r_buf[r_sel][r_cnt];
    end
  end

  always_comb begin
    w_rd = '0;
    if (int'(bus.pwm_addr) < PWM_WIDTH) w_rd = r_buf[r_sel][bus.pwm_addr];
  end

  assign bus.pwm_data      = w_rd;
  assign bus.wr_ready      = w_ready;
  assign bus.frame_pending = r_pending;
endmodule

// File: tb/tb_pwm_bitplane_mem.sv
// tb/tb_pwm_bitplane_mem.sv - directed + random check of pwm_bitplane_mem against a duty-word model
// Follows PWM_COPY_FORWARD_EN the same way as the design build.
module tb_pwm_bitplane_mem;
  localparam int W = 16;
  localparam int N = 4;
`ifdef PWM_COPY_FORWARD_EN
  localparam bit COPY = 1'b1;
`else
  localparam bit COPY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_bitplane_mem_if #(.PWM_WIDTH(W), .NUM_PWM(N)) bus ();
  pwm_bitplane_mem #(.PWM_WIDTH(W), .NUM_PWM(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Model holds whole duty words per channel; planes are derived on read.
  logic [W-1:0] m_act [N];
  logic [W-1:0] m_shd [N];
  bit           m_pending;
  int           m_block;

  function automatic logic [N-1:0] exp_plane(input int a);
    logic [N-1:0] r;
    r = '0;
    for (int c = 0; c < N; c++) if (a < W) r[c] = m_act[c][a];
    return r;
  endfunction

  function automatic bit m_ready();
    return !m_pending && (m_block == 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_ready"},   32'(bus.wr_ready),      32'(m_ready()));
    check({tag, "_pending"}, 32'(bus.frame_pending), 32'(m_pending));
    check({tag, "_data"},    32'(bus.pwm_data),      32'(exp_plane(int'(bus.pwm_addr))));
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_act[c] = '0;
      m_shd[c] = '0;
    end
    m_pending = 1'b0;
    m_block   = 0;
  endtask

  task automatic idle_inputs();
    bus.wr_valid  = 1'b0;
    bus.wr_chan   = '0;
    bus.wr_duty   = '0;
    bus.commit    = 1'b0;
    bus.latch_mem = 1'b0;
  endtask

  // Apply the current inputs to the model, then advance one clock and settle.
  task automatic step();
    bit rdy, cacc, sw;
    logic [W-1:0] t;
    rdy = m_ready();
    if (bus.wr_valid && rdy && int'(bus.wr_chan) < N) m_shd[bus.wr_chan] = bus.wr_duty;
    cacc = bus.commit && rdy;
    sw   = bus.latch_mem && (m_pending || cacc);
    if (cacc) m_pending = 1'b1;
    if (m_block > 0) m_block--;
    if (sw) begin
      for (int c = 0; c < N; c++) begin
        t        = m_act[c];
        m_act[c] = m_shd[c];
        m_shd[c] = COPY ? m_shd[c] : t;
      end
      m_pending = 1'b0;
      m_block   = COPY ? W : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag, input int expect_cycles);
    int n;
    n = 0;
    while (!bus.wr_ready && n < 40) begin
      step();
      check_outs(tag);
      n++;
    end
    check({tag, "_blackout"}, 32'(n), 32'(expect_cycles));
  endtask

  task automatic write(input int ch, input logic [W-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_chan  = ch[1:0];
    bus.wr_duty  = d;
    step();
    bus.wr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.pwm_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int a = 0; a < W; a++) begin
      bus.pwm_addr = a[3:0];
      #1;
      check("reset_sweep", 32'(bus.pwm_data), 32'h0);
    end
    check("reset_ready", 32'(bus.wr_ready), 32'h1);
    check("reset_pending", 32'(bus.frame_pending), 32'h0);

    write(0, 16'h0005);
    write(3, 16'h8001);
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    check_outs("after_commit");
    check("commit_pending", 32'(bus.frame_pending), 32'h1);
    bus.latch_mem = 1'b1;
    bus.pwm_addr  = 4'd0;
    #1;
    check("latch_cycle_old", 32'(bus.pwm_data), 32'h0);
    step();
    bus.latch_mem = 1'b0;
    #1;
    check("frame1_addr0", 32'(bus.pwm_data), 32'h9);
    bus.pwm_addr = 4'd2;
    #1;
    check("frame1_addr2", 32'(bus.pwm_data), 32'h1);
    bus.pwm_addr = 4'd15;
    #1;
    check("frame1_addr15", 32'(bus.pwm_data), 32'h8);
    check("frame1_pending", 32'(bus.frame_pending), 32'h0);
    wait_ready("frame1", COPY ? W : 0);

    write(2, 16'h1234);
    bus.commit = 1'b1;
    step();
    bus.commit   = 1'b0;
    bus.pwm_addr = 4'd0;
    repeat (100) begin
      step();
      check_outs("hold");
    end
    check("hold_pending", 32'(bus.frame_pending), 32'h1);
    check("hold_ready", 32'(bus.wr_ready), 32'h0);
    bus.latch_mem = 1'b1;
    step();
    bus.latch_mem = 1'b0;
    check_outs("hold_swap");
    wait_ready("hold", COPY ? W : 0);

    bus.wr_valid  = 1'b1;
    bus.wr_chan   = 2'd1;
    bus.wr_duty   = 16'h00F0;
    bus.commit    = 1'b1;
    bus.latch_mem = 1'b1;
    bus.pwm_addr  = 4'd4;
    #1;
    check_outs("same_cycle_old");
    step();
    idle_inputs();
    check_outs("same_cycle_new");
    check("same_cycle_pending", 32'(bus.frame_pending), 32'h0);
    wait_ready("same_cycle", COPY ? W : 0);

    write(1, 16'hFFFF);
    bus.commit    = 1'b1;
    bus.latch_mem = 1'b1;
    step();
    idle_inputs();
    bus.pwm_addr = 4'd0;
    #1;
    check_outs("partial");
`ifdef PWM_COPY_FORWARD_EN
    check("partial_addr0", 32'(bus.pwm_data), 32'hB);
`endif
    wait_ready("partial", COPY ? W : 0);

    repeat (400) begin
      bus.wr_valid  = 1'($urandom_range(0, 1));
      bus.wr_chan   = 2'($urandom_range(0, N - 1));
      bus.wr_duty   = 16'($urandom);
      bus.commit    = ($urandom_range(0, 7) == 0);
      bus.latch_mem = ($urandom_range(0, 5) == 0);
      bus.pwm_addr  = 4'($urandom_range(0, W - 1));
      #1;
      check("rand_pre_data", 32'(bus.pwm_data), 32'(exp_plane(int'(bus.pwm_addr))));
      step();
      check_outs("rand");
    end
    idle_inputs();
    bus.latch_mem = 1'b1;
    step();
    bus.latch_mem = 1'b0;
    wait_ready("drain", m_block);

    write(0, 16'($urandom) | 16'h0001);
    bus.commit    = 1'b1;
    bus.latch_mem = 1'b1;
    step();
    idle_inputs();
    repeat (6) step();
    check_outs("before_rst");
    rst = 1'b1;
    #1;
    model_reset();
    check_outs("mid_rst");
    for (int a = 0; a < W; a++) begin
      bus.pwm_addr = a[3:0];
      #1;
      check("mid_rst_sweep", 32'(bus.pwm_data), 32'h0);
    end
    #2;
    rst = 1'b0;
    step();
    check_outs("after_rst");
    check("after_rst_ready", 32'(bus.wr_ready), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
